// File: rtl/ctl_sseg_scan.sv
// Time-multiplexed 4-digit seven-segment scanner with frame-synchronous input
// shadowing, leading-zero blanking and whole-display blink. All outputs are registered.
module ctl_sseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex0,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic [3:0] dp_in,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] sseg,
  output logic       dp
);
  localparam int RCW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RCW-1:0] RC_MAX = RCW'(REFRESH_DIV - 1);
  localparam logic [BCW-1:0] BC_MAX = BCW'(BLINK_DIV - 1);

  logic [RCW-1:0]  rc_q, rc_d;
  logic [1:0]      idx_q, idx_d;
  logic [BCW-1:0]  bc_q, bc_d;
  logic            bp_q, bp_d;
  logic [3:0][3:0] hex_q, hex_d;
  logic [3:0]      dps_q, dps_d;
  logic            blz_q, blz_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      sseg_q, sseg_d;
  logic            dp_q, dp_d;

  logic            rc_wrap, frame, dark;
  logic [3:0]      blank;
  logic [3:0]      digit;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    rc_wrap = (rc_q == RC_MAX);
    frame   = rc_wrap && (idx_q == 2'd3);
    rc_d    = rc_wrap ? '0 : rc_q + RCW'(1);
    idx_d   = rc_wrap ? idx_q + 2'd1 : idx_q;

    // Inputs only land at the frame boundary so a frame never shows mixed values.
    hex_d = frame ? {hex3, hex2, hex1, hex0} : hex_q;
    dps_d = frame ? dp_in : dps_q;
    blz_d = frame ? blank_lz : blz_q;

    bc_d = '0;
    bp_d = 1'b0;
    if (blink_en) begin
      bc_d = (bc_q == BC_MAX) ? '0 : bc_q + BCW'(1);
      bp_d = (bc_q == BC_MAX) ? ~bp_q : bp_q;
    end

    // A digit is leading-zero blanked only if it and every higher digit are zero.
    blank[3] = blz_q && (hex_q[3] == 4'h0);
    blank[2] = blank[3] && (hex_q[2] == 4'h0);
    blank[1] = blank[2] && (hex_q[1] == 4'h0);
    blank[0] = 1'b0;

    dark  = blink_en && bp_q;
    digit = hex_q[idx_q];

    an_d   = 4'hF;
    sseg_d = 7'h7F;
    dp_d   = 1'b1;
    if (!dark && !blank[idx_q]) begin
      an_d         = 4'hF;
      an_d[idx_q]  = 1'b0;
      sseg_d       = glyph(digit);
      dp_d         = ~dps_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q   <= '0;
      idx_q  <= '0;
      bc_q   <= '0;
      bp_q   <= 1'b0;
      hex_q  <= '0;
      dps_q  <= '0;
      blz_q  <= 1'b0;
      an_q   <= 4'hF;
      sseg_q <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      rc_q   <= rc_d;
      idx_q  <= idx_d;
      bc_q   <= bc_d;
      bp_q   <= bp_d;
      hex_q  <= hex_d;
      dps_q  <= dps_d;
      blz_q  <= blz_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      dp_q   <= dp_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;
  assign dp   = dp_q;
endmodule

// File: tb/tb_ctl_sseg_scan.sv
// Random and directed stimulus for ctl_sseg_scan, checked every cycle against a
// cycle-count based reference model (slot = time/refresh, dark = blink time/half-period).
module tb_ctl_sseg_scan;
  localparam int R = 4;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hex0 = '0, hex1 = '0, hex2 = '0, hex3 = '0;
  logic [3:0] dp_in = '0;
  logic       blank_lz = 1'b0;
  logic       blink_en = 1'b0;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, consecutive blink edges, shadowed inputs.
  int         n_t = 0;
  int         b_t = 0;
  logic [3:0] m_hex [4];
  logic [3:0] m_dp  = '0;
  logic       m_blz = 1'b0;
  logic [6:0] glyphs [16];

  ctl_sseg_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .dp_in(dp_in), .blank_lz(blank_lz), .blink_en(blink_en),
    .an(an), .sseg(sseg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from pre-edge model state, compare #1 after the edge, advance model.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_sg;
    logic       e_dp;
    logic [3:0] in_hex [4];
    logic [3:0] in_dp;
    logic       in_blz, lit;
    int         slot;
    in_hex[0] = hex0; in_hex[1] = hex1; in_hex[2] = hex2; in_hex[3] = hex3;
    in_dp = dp_in; in_blz = blank_lz;
    e_an = 4'hF; e_sg = 7'h7F; e_dp = 1'b1;
    if (!rst) begin
      slot = (n_t / R) % 4;
      lit = 1'b1;
      if (m_blz && slot > 0) begin
        lit = 1'b0;
        for (int k = slot; k < 4; k++) if (m_hex[k] != 4'h0) lit = 1'b1;
      end
      if (blink_en && ((b_t / B) % 2 == 1)) lit = 1'b0;
      if (lit) begin
        e_an = ~(4'b0001 << slot);
        e_sg = glyphs[m_hex[slot]];
        e_dp = ~m_dp[slot];
      end
    end
    @(posedge clk);
    #1;
    chk("an", {12'd0, an}, {12'd0, e_an});
    chk("sseg", {9'd0, sseg}, {9'd0, e_sg});
    chk("dp", {15'd0, dp}, {15'd0, e_dp});
    if (rst) begin
      n_t = 0; b_t = 0; m_dp = '0; m_blz = 1'b0;
      for (int k = 0; k < 4; k++) m_hex[k] = '0;
    end else begin
      if (n_t % (4 * R) == 4 * R - 1) begin
        for (int k = 0; k < 4; k++) m_hex[k] = in_hex[k];
        m_dp = in_dp; m_blz = in_blz;
      end
      n_t++;
      b_t = blink_en ? b_t + 1 : 0;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Advance (at most one frame) until the model is at the start of the given slot.
  task automatic to_slot(input int s);
    for (int i = 0; i < 4 * R; i++) if (n_t % (4 * R) != s * R) step();
  endtask

  initial begin
    glyphs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int k = 0; k < 4; k++) m_hex[k] = '0;

    // Reset held 3 cycles, then digit0 shows 0 for R cycles, then digit1.
    rst = 1'b1;
    run(3);
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_sseg", {9'd0, sseg}, 16'h007F);
    rst = 1'b0;
    for (int i = 0; i < R; i++) begin
      step();
      chk("rel_an0", {12'd0, an}, {12'd0, 4'b1110});
      chk("rel_sseg0", {9'd0, sseg}, {9'd0, 7'b1000000});
    end
    step();
    chk("rel_an1", {12'd0, an}, {12'd0, 4'b1101});

    // Ammo display "16" with leading-zero blanking.
    hex0 = 4'h6; hex1 = 4'h1; hex2 = 4'h0; hex3 = 4'h0; blank_lz = 1'b1;
    run(8 * R);
    to_slot(0);
    step();
    chk("ammo_d0", {9'd0, sseg}, {9'd0, 7'b0000010});
    to_slot(1);
    step();
    chk("ammo_d1", {9'd0, sseg}, {9'd0, 7'b1111001});
    to_slot(2);
    step();
    chk("ammo_d2_an", {12'd0, an}, 16'h000F);
    run(4 * R);

    // Frame sync: hex0 changes while slot 1 is showing.
    to_slot(1);
    hex0 = 4'h5;
    run(4 * R);
    to_slot(0);
    step();
    chk("sync_d0", {9'd0, sseg}, {9'd0, 7'b0010010});
    run(4 * R);

    // All zero with blanking: only digit0 lit.
    hex0 = 4'h0; hex1 = 4'h0;
    run(12 * R);

    // Decimal point on digit1, then blink, then reset during slot 2.
    dp_in = 4'b0010; hex3 = 4'h8; hex2 = 4'hA; hex1 = 4'hF;
    run(8 * R);
    blink_en = 1'b1;
    run(3 * 2 * B + 3);
    blink_en = 1'b0;
    run(6);
    to_slot(2);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_an", {12'd0, an}, 16'h000F);
    rst = 1'b0;
    step();
    chk("mid_rst_idx0", {12'd0, an}, {12'd0, 4'b1110});
    run(4 * R);

    // Randomized soak.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        hex0 = 4'($urandom); hex1 = 4'($urandom);
        hex2 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        hex3 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        dp_in = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctl_sseg_scan.md
CTL_SSEG_SCAN -- requirements
Module: ctl_sseg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000; clock cycles each digit is lit (min 2).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000; clock cycles per blink half-period (min 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports hex0..hex3  input  4 each  digit values, hex0 least significant.
REQ-006 SHALL have port dp_in  input  4  decimal point request per digit, bit n = digit n, 1 = lit.
REQ-007 SHALL have port blank_lz  input  1  1 = blank leading zeros.
REQ-008 SHALL have port blink_en  input  1  1 = flash whole display (e.g. driven by no_ammo).
REQ-009 SHALL have port an  output  4  digit anodes, active-low, one-hot-low when lit.
REQ-010 SHALL have port sseg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-012 SHALL keep refresh counter rc (0..REFRESH_DIV-1), incrementing every cycle; at REFRESH_DIV-1 it wraps to 0 and digit index idx (2 bit) advances 3->0 wrapping.
REQ-013 SHALL capture hex0..hex3, dp_in, blank_lz into shadow registers only in the cycle where rc==REFRESH_DIV-1 and idx==3 (frame boundary); mid-frame input changes SHALL NOT affect outputs before the next frame.
REQ-014 SHALL register all outputs: an/sseg/dp reflect the idx and shadow values of the previous cycle (1-cycle latency).
REQ-015 SHALL drive an[idx]=0, other anodes 1, when digit idx is not blanked; all anodes 1 when blanked.
REQ-016 SHALL decode shadow digit value 0-F to standard hex glyphs; 0=1000000, 1=1111001, 6=0000010, 8=0000000, A=0001000, F=0001110.
REQ-017 SHALL, when shadow blank_lz=1, blank digit n (n=3,2,1) iff shadow digits n..3 are all zero; digit 0 SHALL never be leading-zero blanked.
REQ-018 SHALL drive dp=~shadow dp_in[idx] for a lit digit, dp=1 for a blanked digit.
REQ-019 SHALL, while blink_en=1, run blink counter bc (0..BLINK_DIV-1) wrapping and toggling blink phase bp at BLINK_DIV-1; while blink_en=0, bc and bp SHALL be held 0.
REQ-020 SHALL force an=1111, sseg=1111111, dp=1 whenever blink_en=1 and bp=1; rc/idx scanning SHALL continue unaffected.
REQ-021 SHALL make blink_en take effect without frame synchronisation (sampled directly, still through 1-cycle output register).
REQ-022 SHALL, when blink_en rises, show display for BLINK_DIV cycles (bp=0) before the first dark half-period.
REQ-023 SHALL give blanking precedence: blink dark > leading-zero blank > glyph.

Reset
REQ-024 SHALL on rst=1 set rc=0, idx=0, bc=0, bp=0, all shadow registers 0, an=1111, sseg=1111111, dp=1; rst mid-frame SHALL discard the current scan position.
REQ-025 SHALL, on the first rising edge with rst=0, drive an=1110 with sseg=1000000 (shadow zero) for REFRESH_DIV cycles.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-026 SHALL check reset: hold rst 3 cycles, release -> an=1110, sseg=1000000, dp=1 for 4 cycles, then an=1101, sseg=1000000 (blank_lz=0).
REQ-027 SHALL check ammo display: hex1=1, hex0=6, hex3=hex2=0, blank_lz=1, wait one frame boundary -> digit0 sseg=0000010, digit1 sseg=1111001, digits 2,3 an=1111 in their slots.
REQ-028 SHALL check zero: all hex=0, blank_lz=1 -> only digit0 lit with sseg=1000000; digits 1-3 dark.
REQ-029 SHALL check frame sync: change hex0 from 6 to 5 while idx=1 -> digit0 still shows 6 until the next frame (after idx 3 slot), then 0010010.
REQ-030 SHALL check blink: blink_en=1 -> 8 cycles normal scanning, 8 cycles an=1111/sseg=1111111, repeating; blink_en=0 -> normal next cycle.
REQ-031 SHALL check dp and reset mid-op: dp_in=0010 -> dp=0 only in digit1 slot; assert rst during idx=2 -> outputs off next cycle, scan restarts at idx=0.
